// File: rtl/rotl_arbiter.sv
// Two-requester round-robin front end for a shared, registered rotate-left unit.
// One operation in flight; rotate-right is folded onto rotate-left by negating the shift.
module rotl_arbiter #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned SHIFT_WIDTH = 8,
  parameter int unsigned ROT_LATENCY = 1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_req0_valid,
  output logic                   o_req0_ready,
  input  logic                   i_req0_op,
  input  logic [DATA_WIDTH-1:0]  i_req0_data,
  input  logic [SHIFT_WIDTH-1:0] i_req0_shift,
  input  logic                   i_req1_valid,
  output logic                   o_req1_ready,
  input  logic                   i_req1_op,
  input  logic [DATA_WIDTH-1:0]  i_req1_data,
  input  logic [SHIFT_WIDTH-1:0] i_req1_shift,
  output logic                   o_rsp0_valid,
  input  logic                   i_rsp0_ready,
  output logic [DATA_WIDTH-1:0]  o_rsp0_data,
  output logic                   o_rsp1_valid,
  input  logic                   i_rsp1_ready,
  output logic [DATA_WIDTH-1:0]  o_rsp1_data,
  output logic                   o_rot_enable,
  output logic [DATA_WIDTH-1:0]  o_rot_a,
  output logic [DATA_WIDTH-1:0]  o_rot_shift,
  input  logic [DATA_WIDTH-1:0]  i_rot_result,
  output logic                   o_busy
);

  localparam int unsigned CntWidth = (ROT_LATENCY > 1) ? $clog2(ROT_LATENCY) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e                 r_state;
  state_e                 w_next_state;
  logic                   r_owner;
  logic                   r_last_grant;
  logic [DATA_WIDTH-1:0]  r_a;
  logic [SHIFT_WIDTH-1:0] r_shift;
  logic [CntWidth-1:0]    r_cnt;
  logic [DATA_WIDTH-1:0]  r_result;

  logic                   w_grant;
  logic                   w_sel_valid;
  logic                   w_sel_op;
  logic [DATA_WIDTH-1:0]  w_sel_data;
  logic [SHIFT_WIDTH-1:0] w_sel_shift;
  logic [SHIFT_WIDTH-1:0] w_neg_shift;
  logic [SHIFT_WIDTH-1:0] w_eff_shift;
  logic                   w_rsp_ready;
  logic                   w_active;

  // Contested cycles go to the requester that did not win last time.
  always_comb begin
    w_grant = 1'b0;
    if (i_req0_valid && i_req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (i_req1_valid) begin
      w_grant = 1'b1;
    end
  end

  assign w_sel_valid = w_grant ? i_req1_valid : i_req0_valid;
  assign w_sel_op    = w_grant ? i_req1_op    : i_req0_op;
  assign w_sel_data  = w_grant ? i_req1_data  : i_req0_data;
  assign w_sel_shift = w_grant ? i_req1_shift : i_req0_shift;

  // DATA_WIDTH is 2**SHIFT_WIDTH, so (DATA_WIDTH - s) mod DATA_WIDTH is just -s.
  assign w_neg_shift = '0 - w_sel_shift;
  assign w_eff_shift = w_sel_op ? w_neg_shift : w_sel_shift;
  assign w_rsp_ready = r_owner ? i_rsp1_ready : i_rsp0_ready;

  always_comb begin
    w_next_state = r_state;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    case (r_state)
      StIdle: begin
        o_req0_ready = i_req0_valid & ~w_grant;
        o_req1_ready = i_req1_valid & w_grant;
        if (w_sel_valid) w_next_state = StIssue;
      end
      StIssue: w_next_state = StWait;
      StWait:  if (r_cnt == '0) w_next_state = StResp;
      StResp:  if (w_rsp_ready) w_next_state = StIdle;
      default: w_next_state = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_a          <= '0;
      r_shift      <= '0;
      r_cnt        <= '0;
      r_result     <= '0;
    end else begin
      r_state <= w_next_state;
      case (r_state)
        StIdle: begin
          if (w_sel_valid) begin
            r_owner <= w_grant;
            r_a     <= w_sel_data;
            r_shift <= w_eff_shift;
          end
        end
        StIssue: r_cnt <= CntWidth'(ROT_LATENCY - 1);
        StWait: begin
          if (r_cnt == '0) r_result <= i_rot_result;
          else             r_cnt    <= r_cnt - CntWidth'(1);
        end
        StResp:  if (w_rsp_ready) r_last_grant <= r_owner;
        default: ;
      endcase
    end
  end

  assign w_active     = (r_state == StIssue) || (r_state == StWait);
  assign o_rot_enable = (r_state == StIssue);
  assign o_rot_a      = w_active ? r_a : '0;
  assign o_rot_shift  = w_active ? {{(DATA_WIDTH - SHIFT_WIDTH){1'b0}}, r_shift} : '0;
  assign o_rsp0_valid = (r_state == StResp) && !r_owner;
  assign o_rsp1_valid = (r_state == StResp) && r_owner;
  assign o_rsp0_data  = o_rsp0_valid ? r_result : '0;
  assign o_rsp1_data  = o_rsp1_valid ? r_result : '0;
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_rotl_arbiter.sv
// Scoreboard bench for rotl_arbiter: directed corner cases plus randomized two-requester traffic,
// with a behavioural rotator standing in for the external datapath.
module tb_rotl_arbiter;

  localparam int DW = 256;
  localparam int SW = 8;

  typedef struct {
    bit              owner;
    logic [DW-1:0]   data;
    logic [DW-1:0]   exp;
    int              eff;
    int              hs;
  } txn_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          v  [2];
  logic          op [2];
  logic [DW-1:0] d  [2];
  logic [SW-1:0] sh [2];
  logic [1:0]    rr = 2'b11;
  logic [DW-1:0] rot_res = '0;

  wire           rdy0, rdy1, rv0, rv1, rot_en, busy;
  wire [DW-1:0]  rd0, rd1, rot_a, rot_sh;
  wire [1:0]     rdyv = {rdy1, rdy0};

  txn_t          sb[$];
  int            glog[$];
  int            gcyc[$];
  int            tests = 0;
  int            fails = 0;
  int            cyc = 0;
  int            en_cnt = 0;
  int            n_rsp = 0;
  bit [1:0]      hs_pend = 2'b00;
  bit [1:0]      pv = 2'b00;
  bit            auto_en = 1'b0;
  bit            both = 1'b0;
  bit            drop = 1'b0;
  logic [DW-1:0] last_rsp = '0;

  rotl_arbiter dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req0_valid (v[0]),
    .o_req0_ready (rdy0),
    .i_req0_op    (op[0]),
    .i_req0_data  (d[0]),
    .i_req0_shift (sh[0]),
    .i_req1_valid (v[1]),
    .o_req1_ready (rdy1),
    .i_req1_op    (op[1]),
    .i_req1_data  (d[1]),
    .i_req1_shift (sh[1]),
    .o_rsp0_valid (rv0),
    .i_rsp0_ready (rr[0]),
    .o_rsp0_data  (rd0),
    .o_rsp1_valid (rv1),
    .i_rsp1_ready (rr[1]),
    .o_rsp1_data  (rd1),
    .o_rot_enable (rot_en),
    .o_rot_a      (rot_a),
    .o_rot_shift  (rot_sh),
    .i_rot_result (rot_res),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // External rotator: one-cycle registered rotate-left.
  always @(posedge clk) begin
    if (rot_en) rot_res <= (rot_a << rot_sh[SW-1:0]) | (rot_a >> (DW - int'(rot_sh[SW-1:0])));
  end

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: bit i of a left rotate by s comes from bit i-s; of a right rotate from bit i+s.
  function automatic logic [DW-1:0] model(input bit o, input int s, input logic [DW-1:0] a);
    logic [DW-1:0] r;
    for (int i = 0; i < DW; i++) r[i] = a[o ? (i + s) % DW : (i - s + DW) % DW];
    return r;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_req(input int n, input bit o, input logic [DW-1:0] dd, input logic [SW-1:0] s);
    v[n] = 1'b1; op[n] = o; d[n] = dd; sh[n] = s;
  endtask

  task automatic new_req(input int n);
    logic [SW-1:0] s;
    s = SW'($urandom);
    if ($urandom_range(3, 0) == 0) s = $urandom_range(1, 0) ? 8'd0 : 8'd255;
    set_req(n, 1'($urandom), rand_data(), s);
  endtask

  task automatic hold_until_ready(input int n);
    int k = 0;
    do begin @(negedge clk); k++; end while (!rdyv[n] && k < 100);
    if (!rdyv[n]) chk("req_accept_timeout", 0, 1);
    @(posedge clk); #1;
    v[n] = 1'b0;
  endtask

  task automatic send(input int n, input bit o, input logic [DW-1:0] dd, input logic [SW-1:0] s);
    @(posedge clk); #1;
    set_req(n, o, dd, s);
    hold_until_ready(n);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin @(negedge clk); k++; end while ((sb.size() != 0 || busy) && k < 100);
    if (sb.size() != 0 || busy) chk("idle_timeout", 0, 1);
  endtask

  task automatic check_zero(input string name);
    chk(name, {rdy0, rdy1, rv0, rv1, rot_en, busy, |rd0, |rd1, |rot_a, |rot_sh}, 0);
  endtask

  // Request side: record the expected response for every accepted request.
  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      hs_pend[n] = !rst && v[n] && rdyv[n];
      if (hs_pend[n]) begin
        txn_t t;
        t.owner = 1'(n);
        t.data  = d[n];
        t.eff   = op[n] ? (DW - int'(sh[n])) % DW : int'(sh[n]);
        t.exp   = model(op[n], int'(sh[n]), d[n]);
        t.hs    = cyc;
        sb.push_back(t);
        glog.push_back(n);
        gcyc.push_back(cyc);
      end
    end
  end

  // Response side monitor.
  always @(negedge clk) begin
    if (rst) begin
      en_cnt = 0;
      pv = 2'b00;
    end else begin
      chk("ready_rule", !((rdy0 && rdy1) || ((rdy0 || rdy1) && busy)), 1);
      if (rot_en) begin
        en_cnt++;
        if (sb.size() == 0) chk("rot_enable_spurious", 1, 0);
        else begin
          chk("rot_a", rot_a, sb[0].data);
          chk("rot_shift", rot_sh, sb[0].eff);
        end
      end
      for (int n = 0; n < 2; n++) begin
        logic          vld, ovld;
        logic [DW-1:0] rdt, odt;
        vld  = n ? rv1 : rv0;
        rdt  = n ? rd1 : rd0;
        ovld = n ? rv0 : rv1;
        odt  = n ? rd0 : rd1;
        if (vld) begin
          if (sb.size() == 0) chk("rsp_spurious", 1, 0);
          else begin
            chk("rsp_owner", n, sb[0].owner);
            chk("rsp_data", rdt, sb[0].exp);
            chk("rsp_other_zero", ovld | (|odt), 0);
            if (!pv[n]) chk("rsp_latency", cyc - sb[0].hs, 3);
            if (rr[n]) begin
              chk("enable_pulses", en_cnt, 1);
              last_rsp = rdt;
              void'(sb.pop_front());
              en_cnt = 0;
              n_rsp++;
            end
          end
        end
        pv[n] = vld;
      end
    end
  end

  // Random traffic generator, active only while auto_en is set.
  always @(posedge clk) begin
    #1;
    if (auto_en) begin
      for (int n = 0; n < 2; n++) begin
        if (hs_pend[n]) begin
          if (both || $urandom_range(1, 0) == 1) new_req(n);
          else v[n] = 1'b0;
        end else if (!v[n]) begin
          if (both || $urandom_range(2, 0) == 0) new_req(n);
        end else if (drop && $urandom_range(7, 0) == 0) begin
          v[n] = 1'b0;
        end
      end
      rr = drop ? 2'($urandom) : 2'b11;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int k, cnt, n0;
    logic [DW-1:0] held;
    logic [DW-1:0] top_bit;
    top_bit = '0;
    top_bit[DW-1] = 1'b1;
    v[0] = 1'b0; v[1] = 1'b0; op[0] = 1'b0; op[1] = 1'b0;
    d[0] = '0; d[1] = '0; sh[0] = '0; sh[1] = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;

    send(0, 1'b0, 256'h1, 8'd4);    wait_idle(); chk("rotl_1_by_4", last_rsp, 256'h10);
    send(1, 1'b1, 256'h1, 8'd1);    wait_idle(); chk("rotr_1_by_1", last_rsp, top_bit);
    send(0, 1'b0, 256'hA5, 8'd0);   wait_idle(); chk("rotl_by_0", last_rsp, 256'hA5);
    send(1, 1'b1, 256'hA5, 8'd0);   wait_idle(); chk("rotr_by_0", last_rsp, 256'hA5);
    send(0, 1'b0, 256'h1, 8'd255);  wait_idle(); chk("rotl_by_255", last_rsp, top_bit);

    // Response backpressure with the other requester pending.
    @(posedge clk); #1;
    rr[0] = 1'b0;
    set_req(0, 1'b0, rand_data(), 8'd17);
    hold_until_ready(0);
    set_req(1, 1'b1, rand_data(), 8'd3);
    k = 0;
    do begin @(negedge clk); k++; end while (!rv0 && k < 20);
    chk("bp_rsp_seen", rv0, 1);
    held = rd0;
    cnt = 0;
    repeat (10) begin
      if (rv0 && rd0 == held && busy && !rdy0 && !rdy1) cnt++;
      @(negedge clk);
    end
    chk("bp_hold_cycles", cnt, 10);
    @(posedge clk); #1;
    rr[0] = 1'b1;
    hold_until_ready(1);
    wait_idle();

    // Reset while waiting on the rotator.
    @(posedge clk); #1;
    set_req(0, 1'b0, rand_data(), 8'd9);
    hold_until_ready(0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_zero("reset_in_wait");
    cnt = 0;
    repeat (5) begin @(negedge clk); if (rv0 || rv1) cnt++; end
    chk("no_rsp_after_reset", cnt, 0);

    // Both requesters permanently valid: strict alternation starting with req0.
    @(posedge clk); #2;
    glog.delete();
    gcyc.delete();
    both = 1'b1; drop = 1'b0; auto_en = 1'b1;
    k = 0;
    do begin @(negedge clk); k++; end while (glog.size() < 8 && k < 200);
    chk("grant_count", glog.size() >= 8, 1);
    @(posedge clk); #2;
    auto_en = 1'b0; v[0] = 1'b0; v[1] = 1'b0;
    wait_idle();
    for (int i = 0; i < 8 && i < glog.size(); i++) begin
      chk("grant_order", glog[i], i % 2);
      if (i > 0) chk("grant_spacing", gcyc[i] - gcyc[i-1], 4);
    end

    // Random traffic with drops and response backpressure.
    n0 = n_rsp;
    @(posedge clk); #2;
    both = 1'b0; drop = 1'b1; auto_en = 1'b1;
    repeat (400) @(posedge clk);
    #2;
    auto_en = 1'b0; v[0] = 1'b0; v[1] = 1'b0; rr = 2'b11;
    wait_idle();
    chk("random_rsp_count", (n_rsp - n0) > 20, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
